// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions: op encodings, divider sequencer states and width constants.
// The controller and the divider core both size their datapath from XLEN_W.
package m_ext_pkg;

  localparam int unsigned XLEN_W = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [XLEN_W-1:0] INT_MIN  = {1'b1, {(XLEN_W-1){1'b0}}};
  localparam logic [XLEN_W-1:0] ALL_ONES = {XLEN_W{1'b1}};

  // op[0] clear selects the signed flavours, op[1] clear selects the quotient.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_quot(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: magnitude of signed operands and sign of the final result.
// Purely combinational, no latency, no flow control.
module div_sign_fix
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_W
) (
  input  logic [XLEN-1:0] val,
  input  logic            neg,
  output logic [XLEN-1:0] res
);

  // Wraps modulo 2^XLEN, so the magnitude of INT_MIN stays INT_MIN, which the unsigned core expects.
  assign res = neg ? (~val + {{(XLEN-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between execute and the unsigned divider core; special cases finish in 1 cycle, others core latency + 2.
// Accepts only in IDLE (ready_o), holds div_req_o until div_ready_i, kill_i aborts to IDLE without done_o.
module div_ctrl
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_req_o,
  output logic            div_is_q_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_ready_i
);

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, res_q, cap_q;
  logic            req_q, is_q_q, neg_q_q, neg_r_q;

  logic            accept;
  logic            signed_op, quot_op, rs1_neg, rs2_neg;
  logic            div_zero, sgn_ovf, special;
  logic [XLEN-1:0] special_res, a_abs, b_abs, res_fixed;

  assign signed_op = op_is_signed(op_i);
  assign quot_op   = op_is_quot(op_i);
  assign rs1_neg   = signed_op & rs1_i[XLEN-1];
  assign rs2_neg   = signed_op & rs2_i[XLEN-1];

  assign div_zero  = (rs2_i == '0);
  assign sgn_ovf   = signed_op & (rs1_i == INT_MIN) & (rs2_i == ALL_ONES);
  assign special   = div_zero | sgn_ovf;

  // Divide-by-zero takes precedence; the two cases cannot overlap anyway since rs2 differs.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = quot_op ? ALL_ONES : rs1_i;
    end else if (sgn_ovf) begin
      special_res = quot_op ? INT_MIN : '0;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign accept  = valid_i & ready_o & ~kill_i;

  div_sign_fix #(.XLEN(XLEN)) u_abs_a (
    .val (rs1_i),
    .neg (rs1_neg),
    .res (a_abs)
  );

  div_sign_fix #(.XLEN(XLEN)) u_abs_b (
    .val (rs2_i),
    .neg (rs2_neg),
    .res (b_abs)
  );

  div_sign_fix #(.XLEN(XLEN)) u_res_sign (
    .val (cap_q),
    .neg (is_q_q ? neg_q_q : neg_r_q),
    .res (res_fixed)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (div_ready_i) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cap_q   <= '0;
      req_q   <= 1'b0;
      is_q_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (special) begin
              res_q <= special_res;
            end else begin
              a_q     <= a_abs;
              b_q     <= b_abs;
              is_q_q  <= quot_op;
              neg_q_q <= rs1_neg ^ rs2_neg;
              neg_r_q <= rs1_neg;
              req_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Drop req on the completion edge so the core does not start another pass.
          if (div_ready_i && !kill_i) begin
            req_q <= 1'b0;
            cap_q <= div_result_i;
          end
        end
        S_FIX: begin
          if (!kill_i) begin
            res_q <= res_fixed;
          end
        end
        default: ;
      endcase
      if (kill_i) begin
        req_q <= 1'b0;
      end
    end
  end

  assign done_o     = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign result_o   = res_q;
  assign div_a_o    = a_q;
  assign div_b_o    = b_q;
  assign div_req_o  = req_q;
  assign div_is_q_o = is_q_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table for op/sign/special cases plus kill and reset sequences.
module tb_div_ctrl;
  import m_ext_pkg::*;

  localparam int CORE_LAT = 5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o, done_o, busy_o, div_req_o, div_is_q_o;
  logic [31:0] result_o, div_a_o, div_b_o;
  logic [31:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .kill_i       (kill_i),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_req_o    (div_req_o),
    .div_is_q_o   (div_is_q_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          special;
    logic [31:0] a;
    logic [31:0] b;
    logic        isq;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Core response is derived from the expected magnitudes in the vector, not from the DUT.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] core_res;
    string       t;
    t = $sformatf("v%0d", idx);
    chk({t, ".ready_before"}, {31'b0, ready_o}, 32'd1);
    valid_i = 1'b1;
    op_i    = v.op;
    rs1_i   = v.rs1;
    rs2_i   = v.rs2;
    tick();
    valid_i = 1'b0;
    if (v.special) begin
      chk({t, ".done"}, {31'b0, done_o}, 32'd1);
      chk({t, ".req_low"}, {31'b0, div_req_o}, 32'd0);
      chk({t, ".result"}, result_o, v.res);
    end else begin
      chk({t, ".req"}, {31'b0, div_req_o}, 32'd1);
      chk({t, ".a"}, div_a_o, v.a);
      chk({t, ".b"}, div_b_o, v.b);
      chk({t, ".is_q"}, {31'b0, div_is_q_o}, {31'b0, v.isq});
      for (int i = 0; i < CORE_LAT; i++) begin
        tick();
        chk({t, ".req_hold"}, {31'b0, div_req_o & ~done_o}, 32'd1);
      end
      core_res     = v.isq ? (v.a / v.b) : (v.a % v.b);
      div_result_i = core_res;
      div_ready_i  = 1'b1;
      tick();
      div_ready_i  = 1'b0;
      div_result_i = 32'hDEAD_BEEF;
      chk({t, ".req_drop"}, {31'b0, div_req_o}, 32'd0);
      chk({t, ".done_fix"}, {31'b0, done_o}, 32'd0);
      tick();
      chk({t, ".done"}, {31'b0, done_o}, 32'd1);
      chk({t, ".result"}, result_o, v.res);
    end
    tick();
    chk({t, ".done_pulse"}, {31'b0, done_o}, 32'd0);
    chk({t, ".idle"}, {31'b0, ready_o}, 32'd1);
    chk({t, ".result_hold"}, result_o, v.res);
  endtask

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,      32'd7,        1'b0, 32'd100,      32'd7,        1'b1, 32'd14};
    vecs[1]  = '{OP_DIV,  32'hFFFFFF9C, 32'd7,        1'b0, 32'd100,      32'd7,        1'b1, 32'hFFFFFFF2};
    vecs[2]  = '{OP_REM,  32'hFFFFFF9C, 32'd7,        1'b0, 32'd100,      32'd7,        1'b0, 32'hFFFFFFFE};
    vecs[3]  = '{OP_DIV,  32'd5,        32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF};
    vecs[4]  = '{OP_REMU, 32'd5,        32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 32'd5};
    vecs[5]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'd0,        1'b0, 32'h80000000};
    vecs[6]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'd0,        1'b0, 32'd0};
    vecs[7]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 1'b0, 32'd7,        32'd2,        1'b1, 32'hFFFFFFFD};
    vecs[8]  = '{OP_REM,  32'd7,        32'hFFFFFFFE, 1'b0, 32'd7,        32'd2,        1'b0, 32'd1};
    vecs[9]  = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0};
    vecs[10] = '{OP_REMU, 32'hFFFFFFFF, 32'h10,       1'b0, 32'hFFFFFFFF, 32'h10,       1'b0, 32'hF};
    vecs[11] = '{OP_DIV,  32'h80000000, 32'd2,        1'b0, 32'h80000000, 32'd2,        1'b1, 32'hC0000000};
    vecs[12] = '{OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 32'd7,        32'd2,        1'b0, 32'hFFFFFFFF};
    vecs[13] = '{OP_REM,  32'h80000000, 32'd0,        1'b1, 32'd0,        32'd0,        1'b0, 32'h80000000};

    tick();
    tick();
    rst_i = 1'b0;
    chk("rst.ready", {31'b0, ready_o}, 32'd1);
    chk("rst.busy", {31'b0, busy_o}, 32'd0);
    chk("rst.done", {31'b0, done_o}, 32'd0);
    chk("rst.req", {31'b0, div_req_o}, 32'd0);
    chk("rst.result", result_o, 32'd0);
    chk("rst.a", div_a_o, 32'd0);
    chk("rst.b", div_b_o, 32'd0);
    chk("rst.is_q", {31'b0, div_is_q_o}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stray completion pulse while idle must not wake the controller.
    div_ready_i = 1'b1;
    tick();
    div_ready_i = 1'b0;
    chk("stray_ready.busy", {31'b0, busy_o}, 32'd0);
    chk("stray_ready.done", {31'b0, done_o}, 32'd0);

    // Kill beats valid in IDLE.
    valid_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; kill_i = 1'b1;
    tick();
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle.busy", {31'b0, busy_o}, 32'd0);
    chk("kill_idle.req", {31'b0, div_req_o}, 32'd0);

    // Kill in RUN cycle 10, with a coincident core completion that must be dropped.
    valid_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
    tick();
    op_i = OP_REMU; rs1_i = 32'd77; rs2_i = 32'd0;
    chk("kill_run.req", {31'b0, div_req_o}, 32'd1);
    chk("kill_run.not_ready", {31'b0, ready_o}, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    valid_i = 1'b0;
    chk("kill_run.still_busy", {31'b0, busy_o}, 32'd1);
    chk("kill_run.a_stable", div_a_o, 32'd1000);
    kill_i = 1'b1; div_ready_i = 1'b1; div_result_i = 32'd333;
    tick();
    kill_i = 1'b0; div_ready_i = 1'b0;
    chk("kill_run.req_low", {31'b0, div_req_o}, 32'd0);
    chk("kill_run.ready", {31'b0, ready_o}, 32'd1);
    chk("kill_run.result_held", result_o, 32'h80000000);
    for (int i = 0; i < 3; i++) begin
      chk("kill_run.no_done", {31'b0, done_o}, 32'd0);
      tick();
    end
    run_vec('{OP_DIVU, 32'd9, 32'd2, 1'b0, 32'd9, 32'd2, 1'b1, 32'd4}, 100);

    // Synchronous reset mid-RUN returns every output to its reset value.
    valid_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_run.req", {31'b0, div_req_o}, 32'd0);
    chk("rst_run.done", {31'b0, done_o}, 32'd0);
    chk("rst_run.busy", {31'b0, busy_o}, 32'd0);
    chk("rst_run.ready", {31'b0, ready_o}, 32'd1);
    chk("rst_run.result", result_o, 32'd0);
    chk("rst_run.a", div_a_o, 32'd0);
    chk("rst_run.b", div_b_o, 32'd0);
    chk("rst_run.is_q", {31'b0, div_is_q_o}, 32'd0);
    run_vec('{OP_REMU, 32'd17, 32'd5, 1'b0, 32'd17, 32'd5, 1'b0, 32'd2}, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
